// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: class encodings, hold lengths, FSM states.
// The optional wrap-around execution is selected by INSTR_SEQ_LOOP_EN (see instr_sequencer.sv).
package instr_sequencer_pkg;

    localparam int HOLD_W = 3;

    typedef enum logic [1:0] {
        CLS_END   = 2'b00,
        CLS_STD   = 2'b01,
        CLS_LOAD  = 2'b10,
        CLS_STORE = 2'b11
    } cls_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_STD         = 3'd3;
    localparam logic [HOLD_W-1:0] HOLD_LOAD        = 3'd4;
    localparam logic [HOLD_W-1:0] HOLD_STORE       = 3'd3;
    localparam logic [HOLD_W-1:0] HOLD_FIRST_EXTRA = 3'd1;

    // The first word after start also covers the control unit's RESET->DECODE cycle.
    function automatic logic [HOLD_W-1:0] hold_len(input cls_t cls, input logic first);
        logic [HOLD_W-1:0] base;
        case (cls)
            CLS_LOAD:  base = HOLD_LOAD;
            CLS_STORE: base = HOLD_STORE;
            default:   base = HOLD_STD;
        endcase
        return first ? base + HOLD_FIRST_EXTRA : base;
    endfunction

endpackage

// File: rtl/instr_sequencer_hold_timer.sv
// seq_hold_timer: loadable down-counter that flags the last cycle of an instruction's hold window.
// Counts down to zero and rests there until reloaded.
module seq_hold_timer
    import instr_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    output logic              last
);

    logic [HOLD_W-1:0] count_q;
    logic [HOLD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == 3'd1);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches words from a combinational-read memory and holds each on instr
// for its class-specific window. Define INSTR_SEQ_LOOP_EN to wrap from the last address to 0.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt_req,
    output logic [PC_BITS-1:0]     imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             retired,
    output logic [1:0]             dbg_state
);

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [7:0]             retired_q, retired_d;
    logic                   halt_pend_q, halt_pend_d;
    logic                   rst_meta_q, rst_sync_q;

    logic                   hold_load;
    logic [HOLD_W-1:0]      hold_val;
    logic                   hold_last;
    logic                   at_last_addr;
    cls_t                   fetch_cls;

    assign fetch_cls = cls_t'(imem_data[INSTR_WIDTH-1 -: 2]);

`ifdef INSTR_SEQ_LOOP_EN
    assign at_last_addr = 1'b0;
`else
    assign at_last_addr = (pc_q == {PC_BITS{1'b1}});
`endif

    // Reset assertion is immediate; release only takes effect once it has crossed two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        busy_d      = busy_q;
        done_d      = done_q;
        retired_d   = retired_q;
        halt_pend_d = halt_pend_q;
        hold_load   = 1'b0;
        hold_val    = '0;
        imem_addr   = '0;
        case (state_q)
            ST_RUN: begin
                halt_pend_d = halt_pend_q | halt_req;
                if (!hold_last) begin
                    imem_addr = pc_q;
                end else begin
                    imem_addr = pc_q + 1'b1;
                    retired_d = retired_q + 8'd1;
                    if (halt_pend_q || halt_req || fetch_cls == CLS_END || at_last_addr) begin
                        instr_d     = '0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        halt_pend_d = 1'b0;
                        state_d     = ST_DONE;
                    end else begin
                        instr_d   = imem_data;
                        pc_d      = pc_q + 1'b1;
                        hold_load = 1'b1;
                        hold_val  = hold_len(fetch_cls, 1'b0);
                    end
                end
            end
            default: begin
                if (start && !halt_req) begin
                    pc_d = '0;
                    if (fetch_cls == CLS_END) begin
                        instr_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        instr_d   = imem_data;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        hold_load = 1'b1;
                        hold_val  = hold_len(fetch_cls, 1'b1);
                        state_d   = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            pc_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            retired_q   <= '0;
            halt_pend_q <= 1'b0;
        end else if (rst_sync_q) begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            retired_q   <= retired_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    seq_hold_timer u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load & rst_sync_q),
        .load_val (hold_val),
        .last     (hold_last)
    );

    assign instr     = instr_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign retired   = retired_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: hold timing, prefetch address, halt, end-of-memory, reset.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic [4:0]  imem_addr;
    logic [19:0] imem_data;
    logic [19:0] instr;
    logic [4:0]  pc;
    logic        busy;
    logic        done;
    logic [7:0]  retired;
    logic [1:0]  dbg_state;

    logic [19:0] mem [32];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instr_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .halt_req  (halt_req),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .instr     (instr),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .retired   (retired),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 20'h0;
    endtask

    // Leaves the bench at the first falling edge after the accepting rising edge.
    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        clear_mem();

        // Reset state
        step(2);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_retired", retired, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_state", dbg_state, 0);
        rst = 1'b1;
        step(4);

        // std_op then loadR then end
        mem[0] = 20'h41234;
        mem[1] = 20'h85678;
        mem[2] = 20'h00000;
        do_start();
        chk("t1_instr0", instr, 20'h41234);
        chk("t1_busy", busy, 1);
        chk("t1_addr_hold", imem_addr, 0);
        step(3);
        chk("t1_instr0_last", instr, 20'h41234);
        chk("t1_addr_pref0", imem_addr, 1);
        step(1);
        chk("t1_instr1", instr, 20'h85678);
        chk("t1_pc1", pc, 1);
        chk("t1_ret1", retired, 1);
        step(2);
        chk("t1_addr_hold1", imem_addr, 1);
        step(1);
        chk("t1_addr_pref1", imem_addr, 2);
        step(1);
        chk("t1_instr_end", instr, 0);
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_retired", retired, 2);
        chk("t1_state", dbg_state, 2);

        // Three storeR then end: holds 4,3,3
        clear_mem();
        mem[0] = 20'hC0001;
        mem[1] = 20'hC0002;
        mem[2] = 20'hC0003;
        do_start();
        chk("t2_instr0", instr, 20'hC0001);
        chk("t2_done_clr", done, 0);
        step(2);
        chk("t2_addr_hold0", imem_addr, 0);
        step(1);
        chk("t2_addr_pref0", imem_addr, 1);
        step(1);
        chk("t2_instr1", instr, 20'hC0002);
        chk("t2_pc1", pc, 1);
        step(1);
        chk("t2_addr_hold1", imem_addr, 1);
        step(1);
        chk("t2_addr_pref1", imem_addr, 2);
        step(1);
        chk("t2_instr2", instr, 20'hC0003);
        step(2);
        chk("t2_addr_pref2", imem_addr, 3);
        step(1);
        chk("t2_instr_end", instr, 0);
        chk("t2_done", done, 1);
        chk("t2_retired", retired, 5);

        // halt pulsed during the second cycle of a loadR hold
        clear_mem();
        mem[0] = 20'h40001;
        mem[1] = 20'h80002;
        mem[2] = 20'h40003;
        do_start();
        step(5);
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        chk("t3_instr_held", instr, 20'h80002);
        chk("t3_busy_held", busy, 1);
        step(1);
        chk("t3_instr_last", instr, 20'h80002);
        chk("t3_addr_pref", imem_addr, 2);
        step(1);
        chk("t3_instr_end", instr, 0);
        chk("t3_done", done, 1);
        chk("t3_retired", retired, 7);

        // start with halt_req in DONE is ignored
        start = 1'b1;
        halt_req = 1'b1;
        step(1);
        start = 1'b0;
        halt_req = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 1);
        chk("t4_retired", retired, 7);

        // 32 std_op words, no end marker; start while busy ignored
        for (int i = 0; i < 32; i++) mem[i] = 20'h40000 | i;
        do_start();
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t5_restart_instr", instr, 20'h40000);
        chk("t5_restart_busy", busy, 1);
        step(1);
        chk("t5_restart_pc", pc, 0);
        step(91);
        chk("t5_pc31", pc, 31);
        chk("t5_instr31", instr, 20'h4001F);
        step(2);
        chk("t5_addr_wrap", imem_addr, 0);
        step(1);
`ifdef INSTR_SEQ_LOOP_EN
        chk("t5_loop_pc", pc, 0);
        chk("t5_loop_instr", instr, 20'h40000);
        chk("t5_loop_busy", busy, 1);
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        step(4);
        chk("t5_loop_done", done, 1);
`else
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        chk("t5_instr_end", instr, 0);
        chk("t5_retired", retired, 39);
`endif

        // reset mid-run at pc=5
        do_start();
        step(17);
        chk("t6_pc5", pc, 5);
        rst = 1'b0;
        #1;
        chk("t6_instr", instr, 0);
        chk("t6_pc", pc, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_retired", retired, 0);
        chk("t6_addr", imem_addr, 0);
        step(2);

        // release, with start+halt held in IDLE: must be ignored
        rst = 1'b1;
        start = 1'b1;
        halt_req = 1'b1;
        step(1);
        chk("t7_sync_busy", busy, 0);
        step(3);
        chk("t7_ign_busy", busy, 0);
        chk("t7_ign_done", done, 0);
        chk("t7_ign_state", dbg_state, 0);
        halt_req = 1'b0;
        step(1);
        start = 1'b0;
        chk("t7_busy", busy, 1);
        chk("t7_instr", instr, 20'h40000);
        halt_req = 1'b1;
        step(1);
        halt_req = 1'b0;
        step(3);
        chk("t7_halt_done", done, 1);
        chk("t7_halt_retired", retired, 1);
        chk("t7_halt_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter INSTR_WIDTH, default 20, instruction word width.
REQ-002 Parameter PC_BITS, default 5, instruction-memory address width (32 words).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin program execution from address 0; sampled when not busy.
REQ-006 halt_req  input  1  request stop at the next instruction boundary.
REQ-007 imem_addr  output  PC_BITS  instruction-memory address (combinational-read memory).
REQ-008 imem_data  input  INSTR_WIDTH  instruction word at imem_addr, same cycle.
REQ-009 instr  output  INSTR_WIDTH  registered instruction presented to the control unit.
REQ-010 pc  output  PC_BITS  address of the instruction currently on instr.
REQ-011 busy  output  1  program running.
REQ-012 done  output  1  program ended; sticky until next accepted start.
REQ-013 retired  output  8  count of instructions whose hold window completed; wraps 255->0.

Function
REQ-014 Instruction class is instr[19:18]: 01 std_op, 10 loadR, 11 storeR, 00 end-of-program.
REQ-015 Hold length: std_op 3 cycles, loadR 4, storeR 3, matching control-unit DECODE..WRITE_BACK / MEM_ACCESS sequences.
REQ-016 First instruction after an accepted start holds one extra cycle (control-unit RESET->DECODE cycle).
REQ-017 States: IDLE, RUN, DONE; IDLE and DONE differ only in done.
REQ-018 IDLE/DONE: imem_addr=0; on start=1 and halt_req=0, instr<=imem_data, pc<=0, done<=0, busy<=1, load hold counter, go RUN.
REQ-019 start with halt_req=1 in IDLE/DONE is ignored; start while RUN is ignored.
REQ-020 Accepted start with imem_data[19:18]=00: instr stays 0, done<=1, state DONE, busy stays 0.
REQ-021 RUN: hold counter (3 bits) decrements each cycle; instr and pc stable while counter > 1.
REQ-022 RUN, non-final cycles: imem_addr=pc; final cycle (counter==1): imem_addr=pc+1 modulo 2^PC_BITS (prefetch, zero bubble).
REQ-023 Final cycle with continuation: instr<=imem_data, pc<=pc+1, counter loaded per REQ-015, retired<=retired+1.
REQ-024 Final cycle terminates when halt pending, or prefetched class is 00, or pc==2^PC_BITS-1 (see REQ-030): instr<=0, busy<=0, done<=1, retired+1, go DONE.
REQ-025 halt_req asserted any RUN cycle sets a pending flag; never truncates the current hold window; flag cleared on entering DONE.
REQ-026 halt_req and terminating condition in same final cycle: single termination, retired increments once.

Reset
REQ-027 rst low asynchronously forces: state IDLE, instr=0, pc=0, imem_addr=0, busy=0, done=0, retired=0, counter=0, halt pending=0.
REQ-028 Reset mid-RUN abandons the instruction; instr=0 keeps the control unit parked in its RESET state.
REQ-029 Release of rst is synchronised inside the block; first state change occurs no earlier than the second posedge after release.

Configuration
REQ-030 Macro INSTR_SEQ_LOOP_EN: defined -> at pc==2^PC_BITS-1 prefetch wraps to address 0 and execution continues; undefined -> execution terminates per REQ-024 after the last address.
REQ-031 Class-00 and halt termination behave identically with or without INSTR_SEQ_LOOP_EN.

Structure
REQ-032 Shared package holds instruction-class encodings, hold-length constants (3/4/3, +1 first), state enumeration.
REQ-033 One sub-module, seq_hold_timer: loadable 3-bit down-counter with last-cycle flag.

Verification
REQ-034 Program {0x4xxxx std_op, 0x8xxxx loadR, 0x00000} + start -> instr changes after 4, then 4 more cycles, then 0; done=1, retired=2.
REQ-035 Three storeR words then 00 -> holds 4,3,3 cycles; imem_addr=pc+1 only in each final cycle; retired=3.
REQ-036 halt_req pulsed cycle 2 of a loadR hold -> loadR completes full 4 cycles, then instr=0, done=1.
REQ-037 32 std_op words, no 00: without INSTR_SEQ_LOOP_EN -> done after pc=31, retired=32; with it -> pc wraps 31->0, busy stays 1.
REQ-038 rst low during RUN at pc=5 -> same-cycle instr=0, pc=0, busy=0, done=0, retired=0.
REQ-039 start while busy, and start with halt_req=1 in IDLE -> both ignored, no state change.
